// File: rtl/complete_arbiter_pkg.sv
// complete_arbiter_pkg: shared completion types and the SeqAge helper
//   SEQ_NUM_BITS / NUM_PHYS_REGS : codebase-wide widths
//   complete_entry_t             : one buffered writeback/completion
//   seq_age()                    : distance of a seq num from the commit pointer
package complete_arbiter_pkg;
    localparam int SEQ_NUM_BITS  = 5;
    localparam int NUM_PHYS_REGS = 36;
    localparam int PREG_BITS     = $clog2(NUM_PHYS_REGS);

    typedef logic [SEQ_NUM_BITS-1:0] seq_num_t;
    typedef logic [PREG_BITS-1:0]    preg_t;

    typedef struct packed {
        seq_num_t    seq_num;
        preg_t       preg;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        wen;
    } complete_entry_t;

    // SeqAge: wrap-around distance from head; a larger value is younger
    function automatic seq_num_t seq_age(seq_num_t seq, seq_num_t head);
        return seq - head;
    endfunction
endpackage

// File: rtl/complete_arbiter_if.sv
// complete_arbiter_if: requester handshake, squash/age inputs and completion broadcast
//   master : execute pipes + ROB side (drives req_*, head, squash; sees rdy, complete_*)
//   slave  : complete_arbiter
interface complete_arbiter_if
    import complete_arbiter_pkg::*;
#(
    parameter int p_num_reqs      = 2,
    parameter int p_seq_num_bits  = SEQ_NUM_BITS,
    parameter int p_num_phys_regs = NUM_PHYS_REGS
);
    localparam int PB = $clog2(p_num_phys_regs);

    logic [p_num_reqs-1:0]                     req_val;
    logic [p_num_reqs-1:0]                     req_rdy;
    logic [p_num_reqs-1:0][p_seq_num_bits-1:0] req_seq_num;
    logic [p_num_reqs-1:0][PB-1:0]             req_preg;
    logic [p_num_reqs-1:0][4:0]                req_waddr;
    logic [p_num_reqs-1:0][31:0]               req_wdata;
    logic [p_num_reqs-1:0]                     req_wen;
    logic [p_seq_num_bits-1:0]                 head_seq_num;
    logic                                      squash_val;
    logic [p_seq_num_bits-1:0]                 squash_seq_num;
    logic                                      complete_val;
    logic [p_seq_num_bits-1:0]                 complete_seq_num;
    logic [PB-1:0]                             complete_preg;
    logic [4:0]                                complete_waddr;
    logic [31:0]                               complete_wdata;
    logic                                      complete_wen;

    modport master (
        output req_val, req_seq_num, req_preg, req_waddr, req_wdata, req_wen,
               head_seq_num, squash_val, squash_seq_num,
        input  req_rdy, complete_val, complete_seq_num, complete_preg,
               complete_waddr, complete_wdata, complete_wen
    );

    modport slave (
        input  req_val, req_seq_num, req_preg, req_waddr, req_wdata, req_wen,
               head_seq_num, squash_val, squash_seq_num,
        output req_rdy, complete_val, complete_seq_num, complete_preg,
               complete_waddr, complete_wdata, complete_wen
    );
endinterface

// File: rtl/complete_arbiter_rr_pick.sv
// complete_arbiter_rr_pick: rotate-priority picker
//   elig_i : eligible requesters
//   ptr_i  : highest-priority index
//   gnt_o  : one-hot grant, idx_o : granted index, any_o : some grant made
module complete_arbiter_rr_pick #(
    parameter int p_n  = 2,
    parameter int p_pw = 1
) (
    input  logic [p_n-1:0]  elig_i,
    input  logic [p_pw-1:0] ptr_i,
    output logic [p_n-1:0]  gnt_o,
    output logic [p_pw-1:0] idx_o,
    output logic            any_o
);
    // Scan from the farthest position back to ptr so the nearest eligible wins
    always_comb begin
        idx_o = '0;
        any_o = 1'b0;
        gnt_o = '0;
        for (int k = p_n - 1; k >= 0; k--) begin
            if (elig_i[(int'(ptr_i) + k) % p_n]) begin
                idx_o = p_pw'((int'(ptr_i) + k) % p_n);
                any_o = 1'b1;
            end
        end
        if (any_o) gnt_o[idx_o] = 1'b1;
    end
endmodule

// File: rtl/complete_arbiter.sv
// complete_arbiter: one-entry buffer per execute pipe, round-robin onto the single completion port
//   clk, rst_n : clock, async active-low reset
//   bus        : requester handshake, squash/head inputs, completion broadcast
module complete_arbiter
    import complete_arbiter_pkg::*;
#(
    parameter int p_num_reqs      = 2,
    parameter int p_seq_num_bits  = SEQ_NUM_BITS,
    parameter int p_num_phys_regs = NUM_PHYS_REGS
) (
    input  logic              clk,
    input  logic              rst_n,
    complete_arbiter_if.slave bus
);
    localparam int PW = p_num_reqs > 1 ? $clog2(p_num_reqs) : 1;
    localparam int PB = $clog2(p_num_phys_regs);

    complete_entry_t             buf_q [p_num_reqs];
    complete_entry_t             buf_d [p_num_reqs];
    logic [p_num_reqs-1:0]       val_q, val_d;
    logic [PW-1:0]               rr_q, rr_d;
    logic [p_num_reqs-1:0]       killed, in_kill, elig, gnt, rdy, store;
    logic [PW-1:0]               idx;
    logic                        any;
    logic [p_seq_num_bits-1:0]   sq_age;

    assign sq_age = seq_age(bus.squash_seq_num, bus.head_seq_num);

    // Strictly younger than the squasher dies; the squasher itself survives
    always_comb begin
        killed  = '0;
        in_kill = '0;
        for (int i = 0; i < p_num_reqs; i++) begin
            killed[i]  = bus.squash_val && (seq_age(buf_q[i].seq_num, bus.head_seq_num) > sq_age);
            in_kill[i] = bus.squash_val && (seq_age(bus.req_seq_num[i], bus.head_seq_num) > sq_age);
        end
    end

    assign elig = val_q & ~killed;

    complete_arbiter_rr_pick #(.p_n(p_num_reqs), .p_pw(PW)) u_pick (
        .elig_i (elig),
        .ptr_i  (rr_q),
        .gnt_o  (gnt),
        .idx_o  (idx),
        .any_o  (any)
    );

    // A slot frees this cycle if empty, being broadcast, or being squashed
    always_comb begin
        buf_d = buf_q;
        val_d = val_q;
        rdy   = '0;
        store = '0;
        rr_d  = any ? ((idx == PW'(p_num_reqs - 1)) ? '0 : idx + 1'b1) : rr_q;
        for (int i = 0; i < p_num_reqs; i++) begin
            rdy[i]   = rst_n && (!val_q[i] || gnt[i] || killed[i]);
            store[i] = bus.req_val[i] && rdy[i] && !in_kill[i];
            val_d[i] = store[i] || (val_q[i] && !gnt[i] && !killed[i]);
            if (store[i])
                buf_d[i] = '{seq_num: bus.req_seq_num[i], preg: bus.req_preg[i][PB-1:0],
                             waddr: bus.req_waddr[i], wdata: bus.req_wdata[i], wen: bus.req_wen[i]};
        end
    end

    assign bus.req_rdy          = rdy;
    assign bus.complete_val     = rst_n && any;
    assign bus.complete_seq_num = buf_q[idx].seq_num;
    assign bus.complete_preg    = buf_q[idx].preg;
    assign bus.complete_waddr   = buf_q[idx].waddr;
    assign bus.complete_wdata   = buf_q[idx].wdata;
    assign bus.complete_wen     = buf_q[idx].wen;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            val_q <= '0;
            rr_q  <= '0;
        end else begin
            val_q <= val_d;
            rr_q  <= rr_d;
        end
    end

    // Entry payload needs no reset; validity is tracked by val_q
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end
endmodule

// File: tb/tb_complete_arbiter.sv
// tb_complete_arbiter: directed + random stimulus against a behavioural completion model
module tb_complete_arbiter;
    import complete_arbiter_pkg::*;

    localparam int N   = 2;
    localparam int MOD = 1 << SEQ_NUM_BITS;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    complete_arbiter_if #(.p_num_reqs(N)) bus ();
    complete_arbiter #(.p_num_reqs(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_tests = 0;
    int n_fail  = 0;

    bit              m_val [N];
    complete_entry_t m_ent [N];
    int              m_rr;
    int              exp_g;
    bit              exp_kill [N];

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int age(int s);
        return (s - int'(bus.head_seq_num) + MOD) % MOD;
    endfunction

    function automatic bit squashed(int s);
        return bus.squash_val && age(s) > age(int'(bus.squash_seq_num));
    endfunction

    function automatic void model_eval();
        exp_g = -1;
        for (int i = 0; i < N; i++) exp_kill[i] = squashed(int'(m_ent[i].seq_num));
        for (int k = 0; k < N; k++) begin
            int j;
            j = (m_rr + k) % N;
            if (exp_g < 0 && m_val[j] && !exp_kill[j]) exp_g = j;
        end
    endfunction

    task automatic tick();
        logic [N-1:0] rdy;
        #1;
        model_eval();
        for (int i = 0; i < N; i++) rdy[i] = !m_val[i] || exp_g == i || exp_kill[i];
        check("req_rdy", bus.req_rdy, rdy);
        check("complete_val", bus.complete_val, exp_g >= 0);
        if (exp_g >= 0)
            check("complete_fields", {bus.complete_seq_num, bus.complete_preg, bus.complete_waddr,
                                      bus.complete_wdata, bus.complete_wen}, m_ent[exp_g]);
        @(posedge clk);
        for (int i = 0; i < N; i++) begin
            if (bus.req_val[i] && rdy[i] && !squashed(int'(bus.req_seq_num[i]))) begin
                m_val[i] = 1'b1;
                m_ent[i] = '{seq_num: bus.req_seq_num[i], preg: bus.req_preg[i], waddr: bus.req_waddr[i],
                             wdata: bus.req_wdata[i], wen: bus.req_wen[i]};
            end else if (exp_g == i || exp_kill[i]) begin
                m_val[i] = 1'b0;
            end
        end
        if (exp_g >= 0) m_rr = (exp_g + 1) % N;
        @(negedge clk);
    endtask

    task automatic lane(int i, bit v, int seq, int preg = 0, int waddr = 0, logic [31:0] wdata = 0, bit wen = 1);
        bus.req_val[i]     = v;
        bus.req_seq_num[i] = seq_num_t'(seq);
        bus.req_preg[i]    = preg_t'(preg);
        bus.req_waddr[i]   = 5'(waddr);
        bus.req_wdata[i]   = wdata;
        bus.req_wen[i]     = wen;
    endtask

    task automatic idle();
        for (int i = 0; i < N; i++) lane(i, 1'b0, 0);
        bus.squash_val     = 1'b0;
        bus.squash_seq_num = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle();
        bus.head_seq_num = '0;
        for (int i = 0; i < N; i++) m_val[i] = 1'b0;
        m_rr = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        idle();
        bus.head_seq_num = '0;
        #1;
        check("reset_complete_val", bus.complete_val, 0);
        check("reset_req_rdy", bus.req_rdy, 0);
        do_reset();

        // single pipe
        lane(0, 1'b1, 3, 33, 7, 32'hDEADBEEF, 1'b1);
        tick();
        bus.req_val = '0;
        #1;
        check("single_val", bus.complete_val, 1);
        check("single_seq", bus.complete_seq_num, 3);
        check("single_preg", bus.complete_preg, 33);
        check("single_wdata", bus.complete_wdata, 32'hDEADBEEF);
        check("single_rdy0", bus.req_rdy[0], 1);
        tick();
        tick();

        // contention: grants alternate 0,1,0,1 from cycle 1
        do_reset();
        for (int c = 0; c < 6; c++) begin
            lane(0, 1'b1, 2 * c, c, c, 32'(c), 1'b1);
            lane(1, 1'b1, 2 * c + 1, c + 8, c + 8, 32'(c + 100), 1'b0);
            if (c > 0) begin
                #1;
                check("contend_val", bus.complete_val, 1);
                check("contend_who", bus.complete_seq_num[0], (c - 1) % 2);
            end
            tick();
        end
        idle();
        repeat (3) tick();

        // squash kills the younger buffer, keeps the older one
        do_reset();
        bus.head_seq_num = 30;
        lane(0, 1'b1, 2, 5, 2, 32'h2222, 1'b1);
        lane(1, 1'b1, 31, 6, 3, 32'h3131, 1'b1);
        tick();
        bus.req_val        = '0;
        bus.squash_val     = 1'b1;
        bus.squash_seq_num = 1;
        #1;
        check("squash_val", bus.complete_val, 1);
        check("squash_seq", bus.complete_seq_num, 31);
        tick();
        bus.squash_val = 1'b0;
        #1;
        check("squash_after", bus.complete_val, 0);
        tick();

        // wrap / equal seq num
        do_reset();
        bus.head_seq_num = 28;
        lane(0, 1'b1, 29, 10, 4, 32'h29, 1'b1);
        lane(1, 1'b1, 0, 11, 5, 32'h0, 1'b1);
        tick();
        bus.req_val        = '0;
        bus.squash_val     = 1'b1;
        bus.squash_seq_num = 29;
        #1;
        check("wrap_val", bus.complete_val, 1);
        check("wrap_seq", bus.complete_seq_num, 29);
        tick();
        bus.squash_val = 1'b0;
        #1;
        check("wrap_after", bus.complete_val, 0);
        tick();

        // backpressure on requester 1
        do_reset();
        lane(0, 1'b1, 4, 1, 1, 32'h4, 1'b1);
        lane(1, 1'b1, 5, 2, 2, 32'h5, 1'b1);
        tick();
        lane(0, 1'b1, 6, 3, 3, 32'h6, 1'b1);
        #1;
        check("bp_rdy1_blocked", bus.req_rdy[1], 0);
        check("bp_first", bus.complete_seq_num, 4);
        tick();
        lane(0, 1'b1, 8, 4, 4, 32'h8, 1'b1);
        #1;
        check("bp_rdy1_open", bus.req_rdy[1], 1);
        check("bp_second", bus.complete_seq_num, 5);
        tick();
        idle();
        repeat (3) tick();

        // async reset mid-cycle with both buffers full
        do_reset();
        lane(0, 1'b1, 9, 1, 1, 32'h9, 1'b1);
        lane(1, 1'b1, 10, 2, 2, 32'hA, 1'b1);
        tick();
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_complete_val", bus.complete_val, 0);
        check("rst_req_rdy", bus.req_rdy, 0);
        for (int i = 0; i < N; i++) m_val[i] = 1'b0;
        m_rr = 0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        lane(0, 1'b1, 11, 3, 3, 32'hB, 1'b1);
        lane(1, 1'b1, 12, 4, 4, 32'hC, 1'b1);
        tick();
        idle();
        #1;
        check("rst_rr_zero", bus.complete_seq_num, 11);
        tick();
        tick();

        // random traffic with squashes and moving head
        do_reset();
        repeat (400) begin
            for (int i = 0; i < N; i++)
                lane(i, $urandom_range(0, 3) != 0, int'($urandom_range(0, MOD - 1)),
                     int'($urandom_range(0, NUM_PHYS_REGS - 1)), int'($urandom_range(0, 31)),
                     $urandom, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 7) == 0) bus.head_seq_num = seq_num_t'($urandom);
            bus.squash_val     = $urandom_range(0, 3) == 0;
            bus.squash_seq_num = seq_num_t'($urandom);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/complete_arbiter.md
Name: complete_arbiter

Overview:
- Shares the single physical-regfile write port and the CompleteNotif broadcast among p_num_reqs execute pipes.
- Each pipe hands its writeback to a one-entry holding buffer in this block.
- A round-robin scheduler picks one buffered completion per cycle and broadcasts it to the decode/issue rename table and regfile.
- Buffered completions from squashed (younger) instructions are dropped before they can be broadcast.

Parameters:
p_num_reqs, 2, number of execute pipes (requesters); 1..8
p_seq_num_bits, 5, sequence-number width
p_num_phys_regs, 36, physical register count; preg width = $clog2(p_num_phys_regs)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous, active-low reset
req_val  in  [p_num_reqs]  requester i has a completion
req_rdy  out  [p_num_reqs]  requester i's buffer can accept
req_seq_num  in  [p_num_reqs][p_seq_num_bits]  instruction sequence number
req_preg  in  [p_num_reqs][preg bits]  destination physical register
req_waddr  in  [p_num_reqs][5]  architectural destination
req_wdata  in  [p_num_reqs][32]  result data
req_wen  in  [p_num_reqs]  instruction writes a register
head_seq_num  in  p_seq_num_bits  oldest in-flight seq num (commit pointer), age reference
squash_val  in  1  squash broadcast valid
squash_seq_num  in  p_seq_num_bits  seq num of squashing instruction
complete_val  out  1  completion broadcast valid (no backpressure)
complete_seq_num  out  p_seq_num_bits
complete_preg  out  preg bits
complete_waddr  out  5
complete_wdata  out  32
complete_wen  out  1

Behaviour:
- State per requester: a buf_val bit plus the entry fields. Global state: rr_ptr, $clog2(p_num_reqs) bits (min 1).
- Reset (rst_n low, async): all buf_val=0 and rr_ptr=0. complete_val and req_rdy are forced to 0 while in reset. Entry data is don't-care. A reset mid-operation discards all held completions.
- Age: younger(a,b) is true when (a-head_seq_num) mod 2^N > (b-head_seq_num) mod 2^N, using unsigned wrap subtraction.
- Kill: buffer i is killed when squash_val=1 and younger(buf_seq_num[i], squash_seq_num). Equal seq num is not killed, since the squashing instruction itself completes.
- Eligible[i] = buf_val[i] and not killed[i].
- Grant:
  - Pick the first eligible index, searching rr_ptr, rr_ptr+1, … mod p_num_reqs.
  - If none is eligible, complete_val=0; rr_ptr holds and complete_* fields are don't-care.
  - On a grant to g: complete_* = buffer g fields (combinational from registers), complete_val=1, and rr_ptr <= (g+1) mod p_num_reqs.
- Latency: a request accepted at edge t appears on complete_* no earlier than the cycle after edge t. There is no same-cycle bypass.
- Handshake:
  - req_rdy[i] = !buf_val[i] | granted[i] | killed[i].
  - Transfer occurs when req_val[i] & req_rdy[i]; the buffer loads at the next edge.
  - An incoming request that is younger than an active same-cycle squash is consumed (rdy high) but not stored.
- Buffer update priority per i:
  1. Store an accepted, non-killed incoming request.
  2. Otherwise, clear the buffer if it was granted or killed.
  3. Otherwise, hold.
- Full: all buffers occupied and none granted or killed means every req_rdy=0.
- Throughput: one completion per cycle. With N contending requesters, each is granted at least once every N cycles.
- req_wen=0 entries are still arbitrated and broadcast, with complete_wen=0, because the rename table still needs the completion.
- Unused: no other inputs.

Decomposition:
- Shared package (ISA/intf defs): typedef complete_entry_t {seq_num, preg, waddr, wdata, wen}. The preg width is derived from p_num_phys_regs.
- The age compare reuses the codebase's SeqAge utility, with head_seq_num as the reference.
- One sub-module, rr_pick: combinational rotate-priority picker (eligible vector + rr_ptr → one-hot grant + index). The buffers and rr_ptr live in complete_arbiter.

Test Plan:
- Single pipe: req 0 val with seq=3, preg=33, wdata=0xDEADBEEF, wen=1 at cycle 0 → complete_val=1 at cycle 1 with the same fields; req_rdy[0] stays 1 throughout.
- Contention: both reqs valid every cycle from cycle 0, rr_ptr=0 → grants alternate 0,1,0,1 starting at cycle 1; no requester is starved and one complete_val pulse per cycle.
- Squash:
  - Setup: head=30; buf0 holds seq=2, buf1 holds seq=31; squash_val with seq=1.
  - Same cycle: buf0 is killed (age 4>3) and not broadcast; buf1 (age 1) is granted.
  - Next cycle: complete_val=0.
- Wrap/equal: head=28; squash seq=29 while a buffer holds seq=29 → not killed, broadcast normally. A buffer holding seq=0 (age 4) is dropped.
- Backpressure: hold req_val[1] with buffer 1 occupied while rr favours 0 and buffer 0 is continuously refilled → req_rdy[1]=0 until buffer 1 is granted within 2 cycles, then 1.
- Async reset: assert rst_n=0 mid-cycle with both buffers full → complete_val and req_rdy drop immediately. After release, no stale completion is broadcast and rr_ptr=0.
